adc_trigger_gen: RTL and testbench

Self-triggering discriminator that sits directly upstream of the digitizer run-control state machine and drives its `TRIGGER` input. While armed by the controller's `WR_ENABLE`, it watches the ADC sample stream and issues a single-cycle trigger pulse. A pulse fires when the samples cross a programmable threshold for a programmable number of consecutive samples, or when software forces one. A holdoff period and a re-arm condition follow each trigger, so one physical pulse yields one trigger. A trigger count and a sample-index timestamp are kept for the readout path.

---
 rtl/adc_trigger_gen_if.sv | 32 +++
 rtl/adc_trigger_gen.sv | 160 ++++++++++++++++
 tb/tb_adc_trigger_gen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/adc_trigger_gen_if.sv
// Bus between the ADC trigger generator and its environment.
interface adc_trigger_gen_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 8
);
    logic              i_arm;
    logic [DATA_W-1:0] i_adc_data;
    logic              i_adc_valid;
    logic [DATA_W-1:0] i_threshold;
    logic              i_polarity;
    logic [CNT_W-1:0]  i_min_width;
    logic [15:0]       i_holdoff;
    logic              i_sw_trig;
    logic              o_trigger;
    logic              o_trig_src;
    logic [15:0]       o_trig_count;
    logic [15:0]       o_trig_ts;

    // Controller / stimulus side.
    modport master (
        output i_arm, i_adc_data, i_adc_valid, i_threshold, i_polarity,
               i_min_width, i_holdoff, i_sw_trig,
        input  o_trigger, o_trig_src, o_trig_count, o_trig_ts
    );

    // Trigger generator side.
    modport slave (
        input  i_arm, i_adc_data, i_adc_valid, i_threshold, i_polarity,
               i_min_width, i_holdoff, i_sw_trig,
        output o_trigger, o_trig_src, o_trig_count, o_trig_ts
    );
endinterface

// File: rtl/adc_trigger_gen.sv
// Self-triggering threshold discriminator with software force, holdoff and re-arm.
module adc_trigger_gen #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    adc_trigger_gen_if.slave bus
);
    localparam int unsigned TS_W = 16;
    localparam int unsigned HO_W = 16;
    localparam int unsigned QC_W = CNT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_QUALIFY,
        S_FIRE,
        S_HOLDOFF,
        S_REARM
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_qcnt;
    logic [CNT_W-1:0] w_qcnt_nxt;
    logic [TS_W-1:0]  r_idx;
    logic [HO_W-1:0]  r_hold;
    logic             r_src_pend;
    logic [TS_W-1:0]  r_qual_ts;
    logic             r_trigger;
    logic             r_trig_src;
    logic [15:0]      r_trig_count;
    logic [TS_W-1:0]  r_trig_ts;

    logic             w_over;
    logic             w_valid_over;
    logic             w_valid_under;
    logic [CNT_W-1:0] w_eff_width;
    logic [QC_W-1:0]  w_qcnt_inc;
    logic             w_fire_sw;
    logic             w_fire_thr;

    // Strict unsigned compare in the selected direction; zero width means one.
    assign w_over        = bus.i_polarity ? (bus.i_adc_data < bus.i_threshold)
                                          : (bus.i_adc_data > bus.i_threshold);
    assign w_valid_over  = bus.i_adc_valid & w_over;
    assign w_valid_under = bus.i_adc_valid & ~w_over;
    assign w_eff_width   = (bus.i_min_width == '0) ? CNT_W'(1) : bus.i_min_width;
    assign w_qcnt_inc    = {1'b0, r_qcnt} + QC_W'(1);

    // Next-state logic; losing arm aborts everything except an in-flight FIRE.
    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        w_fire_sw   = 1'b0;
        w_fire_thr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_arm) w_state_nxt = S_SEARCH;
            end
            S_SEARCH: begin
                if (!bus.i_arm) begin
                    w_state_nxt = S_IDLE;
                    w_qcnt_nxt  = '0;
                end else if (bus.i_sw_trig) begin
                    w_state_nxt = S_FIRE;
                    w_fire_sw   = 1'b1;
                end else if (w_valid_over) begin
                    if (w_eff_width == CNT_W'(1)) begin
                        w_state_nxt = S_FIRE;
                        w_fire_thr  = 1'b1;
                    end else begin
                        w_state_nxt = S_QUALIFY;
                        w_qcnt_nxt  = CNT_W'(1);
                    end
                end
            end
            S_QUALIFY: begin
                if (!bus.i_arm) begin
                    w_state_nxt = S_IDLE;
                    w_qcnt_nxt  = '0;
                end else if (bus.i_sw_trig) begin
                    w_state_nxt = S_FIRE;
                    w_qcnt_nxt  = '0;
                    w_fire_sw   = 1'b1;
                end else if (w_valid_over) begin
                    if (w_qcnt_inc == {1'b0, w_eff_width}) begin
                        w_state_nxt = S_FIRE;
                        w_qcnt_nxt  = '0;
                        w_fire_thr  = 1'b1;
                    end else begin
                        w_qcnt_nxt  = w_qcnt_inc[CNT_W-1:0];
                    end
                end else if (w_valid_under) begin
                    w_state_nxt = S_SEARCH;
                    w_qcnt_nxt  = '0;
                end
            end
            S_FIRE: begin
                w_state_nxt = bus.i_arm ? S_HOLDOFF : S_IDLE;
            end
            S_HOLDOFF: begin
                if (!bus.i_arm)             w_state_nxt = S_IDLE;
                else if (r_hold <= HO_W'(1)) w_state_nxt = S_REARM;
            end
            S_REARM: begin
                if (!bus.i_arm)        w_state_nxt = S_IDLE;
                else if (w_valid_under) w_state_nxt = S_SEARCH;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_qcnt_nxt  = '0;
            end
        endcase
    end

    // State, sample index, holdoff timer and readout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_qcnt       <= '0;
            r_idx        <= '0;
            r_hold       <= '0;
            r_src_pend   <= 1'b0;
            r_qual_ts    <= '0;
            r_trigger    <= 1'b0;
            r_trig_src   <= 1'b0;
            r_trig_count <= '0;
            r_trig_ts    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_qcnt    <= w_qcnt_nxt;
            r_trigger <= (w_state_nxt == S_FIRE);

            if (!bus.i_arm)           r_idx <= '0;
            else if (bus.i_adc_valid) r_idx <= r_idx + TS_W'(1);

            // Remember the source and the qualifying sample's index for FIRE.
            if (w_fire_sw || w_fire_thr) begin
                r_src_pend <= w_fire_sw;
                r_qual_ts  <= r_idx;
            end

            if (r_state == S_FIRE) begin
                r_trig_src <= r_src_pend;
                r_trig_ts  <= r_src_pend ? r_idx : r_qual_ts;
                if (r_trig_count != 16'hFFFF) r_trig_count <= r_trig_count + 16'd1;
                r_hold <= (bus.i_holdoff == '0) ? HO_W'(1) : bus.i_holdoff;
            end else if (r_state == S_HOLDOFF && r_hold != '0) begin
                r_hold <= r_hold - HO_W'(1);
            end
        end
    end

    assign bus.o_trigger    = r_trigger;
    assign bus.o_trig_src   = r_trig_src;
    assign bus.o_trig_count = r_trig_count;
    assign bus.o_trig_ts    = r_trig_ts;
endmodule

// File: tb/tb_adc_trigger_gen.sv
// Directed scoreboard bench for adc_trigger_gen.
module tb_adc_trigger_gen;
    logic clk = 1'b0;
    logic rst;

    int n_vec = 0;
    int n_err = 0;

    logic  exp_q[$];
    string tag_q[$];

    adc_trigger_gen_if #(.DATA_W(12), .CNT_W(8)) bus ();

    adc_trigger_gen #(.DATA_W(12), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle of input, queue the expected trigger, compare after the edge.
    task automatic step(input logic v, input logic [11:0] d, input logic sw,
                        input logic exp_trig, input string tag);
        logic  e;
        string t;
        bus.i_adc_valid = v;
        bus.i_adc_data  = d;
        bus.i_sw_trig   = sw;
        exp_q.push_back(exp_trig);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_vec++;
        assert (bus.o_trigger === e)
        else begin
            n_err++;
            $error("FAIL %s trigger observed=%0b expected=%0b", t, bus.o_trigger, e);
        end
        bus.i_sw_trig = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_arm       = 1'b0;
        bus.i_adc_data  = '0;
        bus.i_adc_valid = 1'b0;
        bus.i_threshold = 12'd100;
        bus.i_polarity  = 1'b0;
        bus.i_min_width = 8'd3;
        bus.i_holdoff   = 16'd1;
        bus.i_sw_trig   = 1'b0;

        step(0, 0, 0, 0, "rst0");
        step(0, 0, 0, 0, "rst1");
        chk("rst_src",   16'(bus.o_trig_src), 16'd0);
        chk("rst_count", bus.o_trig_count, 16'd0);
        chk("rst_ts",    bus.o_trig_ts, 16'd0);
        rst = 1'b0;

        // Basic threshold trigger, width 3.
        bus.i_arm = 1'b1;
        step(0, 0,   0, 0, "b_arm");
        step(1, 50,  0, 0, "b_50");
        step(1, 120, 0, 0, "b_120");
        step(1, 130, 0, 0, "b_130");
        step(1, 140, 0, 1, "b_140");
        step(0, 0,   0, 0, "b_fire");
        chk("b_ts",    bus.o_trig_ts, 16'd3);
        chk("b_count", bus.o_trig_count, 16'd1);
        chk("b_src",   16'(bus.o_trig_src), 16'd0);
        step(0, 0,  0, 0, "b_hold");
        step(1, 50, 0, 0, "b_rearm");

        // Glitch rejection after a fresh arm.
        bus.i_arm = 1'b0;
        step(0, 0, 0, 0, "g_disarm");
        bus.i_arm = 1'b1;
        step(0, 0,   0, 0, "g_arm");
        step(1, 120, 0, 0, "g_120a");
        step(1, 130, 0, 0, "g_130a");
        step(1, 90,  0, 0, "g_90");
        step(1, 120, 0, 0, "g_120b");
        step(1, 130, 0, 0, "g_130b");
        step(1, 140, 0, 1, "g_140");
        step(0, 0,   0, 0, "g_fire");
        chk("g_ts",    bus.o_trig_ts, 16'd5);
        chk("g_count", bus.o_trig_count, 16'd2);

        // Holdoff with continuous over-samples, then re-arm by a low sample.
        step(0, 0,  0, 0, "h_hold");
        step(1, 50, 0, 0, "h_rearm");
        bus.i_min_width = 8'd1;
        bus.i_holdoff   = 16'd10;
        step(1, 150, 0, 1, "h_trig");
        step(1, 150, 0, 0, "h_fire");
        chk("h_ts",    bus.o_trig_ts, 16'd7);
        chk("h_count", bus.o_trig_count, 16'd3);
        for (int i = 0; i < 12; i++) step(1, 150, 0, 0, "h_held");
        step(1, 80, 0, 0, "h_80");
        bus.i_holdoff = 16'd2;
        step(1, 150, 0, 1, "h_retrig");
        step(0, 0,   0, 0, "h_fire2");
        chk("h_ts2",    bus.o_trig_ts, 16'd22);
        chk("h_count2", bus.o_trig_count, 16'd4);

        // Software trigger: ignored in HOLDOFF and REARM, honoured in SEARCH.
        step(0, 0,  1, 0, "s_in_hold");
        step(1, 80, 0, 0, "s_hold_end");
        step(1, 80, 1, 0, "s_in_rearm");
        step(0, 0,  1, 1, "s_in_search");
        step(0, 0,  0, 0, "s_fire");
        chk("s_src",   16'(bus.o_trig_src), 16'd1);
        chk("s_ts",    bus.o_trig_ts, 16'd25);
        chk("s_count", bus.o_trig_count, 16'd5);
        bus.i_arm = 1'b0;
        step(0, 0, 0, 0, "s_disarm");
        step(0, 0, 1, 0, "s_in_idle");
        bus.i_arm = 1'b1;
        step(0, 0, 1, 0, "s_idle_arm");

        // Arm drop on the would-be qualifying sample, then restart from index 0.
        bus.i_min_width = 8'd3;
        bus.i_holdoff   = 16'd1;
        step(1, 120, 0, 0, "a_120");
        step(1, 130, 0, 0, "a_130");
        bus.i_arm = 1'b0;
        step(1, 140, 0, 0, "a_drop");
        bus.i_arm = 1'b1;
        step(0, 0,   0, 0, "a_rearm");
        step(1, 120, 0, 0, "a_120b");
        step(1, 130, 0, 0, "a_130b");
        step(1, 140, 0, 1, "a_140b");
        step(0, 0,   0, 0, "a_fire");
        chk("a_ts",    bus.o_trig_ts, 16'd2);
        chk("a_src",   16'(bus.o_trig_src), 16'd0);
        chk("a_count", bus.o_trig_count, 16'd6);

        // Reset during HOLDOFF.
        rst = 1'b1;
        step(0, 0, 0, 0, "r_rst");
        chk("r_src",   16'(bus.o_trig_src), 16'd0);
        chk("r_count", bus.o_trig_count, 16'd0);
        chk("r_ts",    bus.o_trig_ts, 16'd0);
        rst = 1'b0;

        // Falling polarity, width 0, with invalid gaps.
        bus.i_polarity  = 1'b1;
        bus.i_threshold = 12'd500;
        bus.i_min_width = 8'd0;
        step(0, 0,   0, 0, "p_arm");
        step(1, 600, 0, 0, "p_600");
        step(0, 300, 0, 0, "p_gap300");
        step(1, 700, 0, 0, "p_700");
        step(0, 0,   0, 0, "p_gap");
        step(1, 500, 0, 0, "p_500");
        step(0, 100, 0, 0, "p_gap100");
        step(1, 499, 0, 1, "p_499");
        step(0, 0,   0, 0, "p_fire");
        chk("p_ts",    bus.o_trig_ts, 16'd3);
        chk("p_count", bus.o_trig_count, 16'd1);
        chk("p_src",   16'(bus.o_trig_src), 16'd0);

        // Software request wins over a same-cycle qualifying sample.
        step(0, 0,   0, 0, "q_hold");
        step(1, 600, 0, 0, "q_rearm");
        step(1, 400, 1, 1, "q_both");
        step(0, 0,   0, 0, "q_fire");
        chk("q_src",   16'(bus.o_trig_src), 16'd1);
        chk("q_count", bus.o_trig_count, 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
